// File: rtl/postmortem_capture_ctrl.sv
`default_nettype none
// postmortem_capture_ctrl: samples N_CH 64-bit channel words each PERIOD clocks into per-channel
// DDR ring buffers and freezes POST samples after an interlock rising edge.
module postmortem_capture_ctrl #(
   parameter int          N_CH       = 5,
   parameter int          PERIOD     = 4000,
   parameter int          DEPTH      = 50000,
   parameter int          POST       = 25000,
   parameter logic [39:0] BASE_ADDR  = 40'h00_0010_0000,
   parameter logic [39:0] STRIDE     = 40'h00_0010_0000,
   parameter bit          AUTO_REARM = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_en,
   input  logic [N_CH*64-1:0]  i_data,
   input  logic                i_intl_flag,
   input  logic                i_rearm,
   output logic                o_start,
   input  logic                i_done,
   output logic [39:0]         o_ddr_addr,
   output logic [63:0]         o_ddr_data,
   output logic [15:0]         o_wr_ptr,
   output logic [15:0]         o_trig_ptr,
   output logic                o_triggered,
   output logic                o_frozen,
   output logic                o_overrun,
   output logic [1:0]          o_state
);

   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int PC_W  = $clog2(POST + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [N_CH*64-1:0] snap;
   logic [2:0]         ch;
   logic [PC_W-1:0]    post_cnt;
   logic               flag_q;
   logic               counted;
   logic               tick;
   logic               trig_fire;
   logic               rearm;
   logic               last_ch;

   function automatic logic [39:0] addr_of(input logic [2:0] c, input logic [15:0] p);
      return BASE_ADDR + 40'(c) * STRIDE + {21'd0, p, 3'b000};
   endfunction

   function automatic logic [15:0] ptr_inc(input logic [15:0] p);
      return (p == 16'(DEPTH - 1)) ? 16'd0 : p + 16'd1;
   endfunction

   assign tick      = i_en && !o_frozen && (cnt == CNT_W'(PERIOD - 1));
   assign trig_fire = i_intl_flag && !flag_q && !o_triggered && !o_frozen;
   // Manual mode only honours i_rearm once the interlock has cleared; auto mode re-arms on
   // the first low flag cycle, which also aborts a capture still collecting post samples.
   assign rearm     = AUTO_REARM ? ((o_triggered || o_frozen) && !i_intl_flag)
                                 : (i_rearm && !i_intl_flag);
   assign last_ch   = (ch == 3'(N_CH - 1));
   assign o_state   = state;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      o_start  = 1'b0;
      case (state)
         IDLE:    if (tick) state_nx = WRITE;
         WRITE: begin
            o_start = 1'b1;
            if (i_done && last_ch) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt <= '0;
      end else if (!i_en || o_frozen || rearm || (cnt == CNT_W'(PERIOD - 1))) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         snap        <= '0;
         ch          <= '0;
         o_ddr_addr  <= '0;
         o_ddr_data  <= '0;
         o_wr_ptr    <= '0;
         o_trig_ptr  <= '0;
         o_triggered <= 1'b0;
         o_frozen    <= 1'b0;
         o_overrun   <= 1'b0;
         post_cnt    <= '0;
         counted     <= 1'b0;
         flag_q      <= 1'b0;
      end else begin
         flag_q <= i_intl_flag;

         if (state == IDLE && tick) begin
            snap       <= i_data;
            ch         <= 3'd0;
            o_ddr_addr <= addr_of(3'd0, o_wr_ptr);
            o_ddr_data <= i_data[63:0];
            counted    <= o_triggered || trig_fire;
         end else if (state == WRITE && i_done && !last_ch) begin
            ch         <= ch + 3'd1;
            o_ddr_addr <= addr_of(ch + 3'd1, o_wr_ptr);
            o_ddr_data <= snap[(int'(ch) + 1) * 64 +: 64];
         end

         if (tick && state != IDLE) o_overrun <= 1'b1;

         if (state == DONE) o_wr_ptr <= ptr_inc(o_wr_ptr);

         if (rearm) begin
            o_triggered <= 1'b0;
            o_frozen    <= 1'b0;
            o_overrun   <= 1'b0;
            post_cnt    <= '0;
            counted     <= 1'b0;
         end else begin
            // A sample already in flight when the edge arrives belongs to the pre-trigger window.
            if (trig_fire) begin
               o_triggered <= 1'b1;
               o_trig_ptr  <= (state == IDLE) ? o_wr_ptr : ptr_inc(o_wr_ptr);
            end
            if (state == DONE && counted) begin
               post_cnt <= post_cnt + PC_W'(1);
               if (post_cnt == PC_W'(POST - 1)) o_frozen <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_postmortem_capture_ctrl.sv
`default_nettype none
// tb_postmortem_capture_ctrl: directed stimulus with a transaction-level model of the capture
// rules, checked every cycle, plus hand-computed expectations for the key scenarios.
module tb_postmortem_capture_ctrl;

   localparam int          N_CH   = 2;
   localparam int          PERIOD = 10;
   localparam int          DEPTH  = 8;
   localparam int          POST   = 3;
   localparam logic [39:0] BASE   = 40'h1000;
   localparam logic [39:0] STRIDE = 40'h100;

   logic                clk    = 1'b0;
   logic                rst_n  = 1'b1;
   logic                en     = 1'b0;
   logic                flag   = 1'b0;
   logic                rearm  = 1'b0;
   logic                done   = 1'b0;
   logic                hold   = 1'b0;
   logic                churn  = 1'b0;
   logic [N_CH*64-1:0]  data   = '0;

   logic                o_start;
   logic [39:0]         o_ddr_addr;
   logic [63:0]         o_ddr_data;
   logic [15:0]         o_wr_ptr;
   logic [15:0]         o_trig_ptr;
   logic                o_triggered;
   logic                o_frozen;
   logic                o_overrun;
   logic [1:0]          o_state;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   postmortem_capture_ctrl #(
      .N_CH(N_CH), .PERIOD(PERIOD), .DEPTH(DEPTH), .POST(POST),
      .BASE_ADDR(BASE), .STRIDE(STRIDE), .AUTO_REARM(1'b0)
   ) dut (
      .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_data(data),
      .i_intl_flag(flag), .i_rearm(rearm), .o_start(o_start), .i_done(done),
      .o_ddr_addr(o_ddr_addr), .o_ddr_data(o_ddr_data), .o_wr_ptr(o_wr_ptr),
      .o_trig_ptr(o_trig_ptr), .o_triggered(o_triggered), .o_frozen(o_frozen),
      .o_overrun(o_overrun), .o_state(o_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic bound(input string nm, input int n, input int lim);
      chk(nm, 64'(n < lim), 64'd1);
   endtask

   // ---------------- model: sample transactions as a queue of pending beats ----------------
   int  m_cnt, m_wr, m_tp, m_post;
   bit  m_trig, m_frz, m_ovr, m_done, m_cntd, m_prev;
   logic [39:0] qa[$];
   logic [63:0] qd[$];

   task automatic model_reset();
      m_cnt = 0; m_wr = 0; m_tp = 0; m_post = 0;
      m_trig = 0; m_frz = 0; m_ovr = 0; m_done = 0; m_cntd = 0; m_prev = 0;
      qa.delete(); qd.delete();
   endtask

   task automatic model_step();
      bit tick, idle, fire, rarm, trig0;
      tick  = en && !m_frz && (m_cnt == PERIOD - 1);
      idle  = (qa.size() == 0) && !m_done;
      fire  = flag && !m_prev && !m_trig && !m_frz;
      rarm  = rearm && !flag;
      trig0 = m_trig;
      m_cnt  = (!en || m_frz || rarm) ? 0 : (m_cnt + 1) % PERIOD;
      m_prev = flag;
      if (tick && !idle) m_ovr = 1;
      if (fire) begin
         m_trig = 1;
         m_tp   = idle ? m_wr : (m_wr + 1) % DEPTH;
      end
      if (idle && tick) begin
         for (int k = 0; k < N_CH; k++) begin
            qa.push_back(BASE + STRIDE * k + 40'(m_wr * 8));
            qd.push_back(data[k*64 +: 64]);
         end
         m_cntd = trig0 || fire;
      end else if (qa.size() != 0) begin
         if (done) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
            if (qa.size() == 0) m_done = 1;
         end
      end else if (m_done) begin
         m_done = 0;
         m_wr   = (m_wr + 1) % DEPTH;
         if (m_cntd) begin
            m_post++;
            if (m_post == POST) m_frz = 1;
         end
      end
      if (rarm) begin
         m_trig = 0; m_frz = 0; m_post = 0; m_ovr = 0; m_cntd = 0;
      end
   endtask

   initial begin : model
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         cyc++;
         chk("start", 64'(o_start), 64'(qa.size() != 0));
         if (qa.size() != 0) begin
            chk("addr", 64'(o_ddr_addr), 64'(qa[0]));
            chk("wdata", o_ddr_data, qd[0]);
         end
         chk("wr_ptr", 64'(o_wr_ptr), 64'(m_wr));
         chk("trig_ptr", 64'(o_trig_ptr), 64'(m_tp));
         chk("triggered", 64'(o_triggered), 64'(m_trig));
         chk("frozen", 64'(o_frozen), 64'(m_frz));
         chk("overrun", 64'(o_overrun), 64'(m_ovr));
         chk("state", 64'(o_state), (qa.size() != 0) ? 64'd1 : (m_done ? 64'd2 : 64'd0));
      end
   end

   // DDR writer stand-in: acknowledges each beat on its second cycle unless stalled.
   initial begin : responder
      int wc;
      wc = 0;
      forever begin
         @(negedge clk);
         if (done) begin
            done = 1'b0;
            wc   = 0;
         end else if (o_start && !hold) begin
            if (wc == 1) done = 1'b1;
            else         wc++;
         end else begin
            wc = 0;
         end
      end
   end

   initial begin : churner
      forever begin
         @(negedge clk);
         if (churn) data = {32'hC1C1_C1C1, 32'(cyc), 32'hC0C0_C0C0, 32'(cyc)};
      end
   end

   initial begin : main
      int n;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_start", 64'(o_start), 64'd0);
      chk("rst_wr_ptr", 64'(o_wr_ptr), 64'd0);
      chk("rst_trig_ptr", 64'(o_trig_ptr), 64'd0);
      chk("rst_flags", {61'd0, o_triggered, o_frozen, o_overrun}, 64'd0);
      chk("rst_state", 64'(o_state), 64'd0);
      chk("rst_addr", 64'(o_ddr_addr), 64'd0);
      rst_n = 1'b1;
      data  = {64'hB1B1_0000_0000_0001, 64'hA0A0_0000_0000_0001};
      @(negedge clk);
      en = 1'b1;

      // sample 0 addresses and data; then data changes before the channel-1 beat
      n = 0; while (!o_start && n < 50) begin @(negedge clk); n++; end
      bound("t1_first_start", n, 50);
      chk("t1_addr_ch0", 64'(o_ddr_addr), 64'h1000);
      chk("t1_data_ch0", o_ddr_data, 64'hA0A0_0000_0000_0001);
      data = {64'hDEAD_0000_0000_0002, 64'hBEEF_0000_0000_0002};
      n = 0; while (!(o_start && o_ddr_addr == 40'h1100) && n < 50) begin @(negedge clk); n++; end
      bound("t2_ch1_beat", n, 50);
      chk("t2_data_ch1", o_ddr_data, 64'hB1B1_0000_0000_0001);
      churn = 1'b1;

      n = 0; while (!(o_state == 2'd2 && o_wr_ptr == 16'd7) && n < 200) begin @(negedge clk); n++; end
      bound("t1_reach7", n, 200);
      @(negedge clk);
      chk("t1_wrap", 64'(o_wr_ptr), 64'd0);

      // interlock edge in IDLE at index 5
      n = 0; while (!(o_state == 2'd2 && o_wr_ptr == 16'd4) && n < 200) begin @(negedge clk); n++; end
      bound("t3_reach4", n, 200);
      @(negedge clk);
      chk("t3_idle", 64'(o_state), 64'd0);
      flag = 1'b1;
      @(negedge clk);
      chk("t3_trig", 64'(o_triggered), 64'd1);
      chk("t3_trig_ptr", 64'(o_trig_ptr), 64'd5);
      n = 0; while (!o_frozen && n < 200) begin @(negedge clk); n++; end
      bound("t3_freeze", n, 200);
      chk("t3_frozen_ptr", 64'(o_wr_ptr), 64'd0);
      n = 0;
      repeat (30) begin @(negedge clk); if (o_start) n++; end
      chk("t3_quiet", 64'(n), 64'd0);

      rearm = 1'b1; @(negedge clk); rearm = 1'b0;
      chk("t3_rearm_flag_hi", 64'(o_frozen), 64'd1);
      flag = 1'b0; @(negedge clk);
      chk("t3_no_auto_rearm", 64'(o_frozen), 64'd1);
      rearm = 1'b1; @(negedge clk); rearm = 1'b0;
      chk("t3_rearm_frozen", 64'(o_frozen), 64'd0);
      chk("t3_rearm_trig", 64'(o_triggered), 64'd0);

      // interlock edge while sample 2 is being written
      n = 0; while (!(o_state == 2'd1 && o_wr_ptr == 16'd2) && n < 200) begin @(negedge clk); n++; end
      bound("t4_reach2", n, 200);
      flag = 1'b1;
      @(negedge clk);
      chk("t4_trig_ptr", 64'(o_trig_ptr), 64'd3);
      n = 0; while (!o_frozen && n < 200) begin @(negedge clk); n++; end
      bound("t4_freeze", n, 200);
      chk("t4_frozen_ptr", 64'(o_wr_ptr), 64'd6);
      flag = 1'b0; @(negedge clk);
      rearm = 1'b1; @(negedge clk); rearm = 1'b0;

      // stalled writer causes an overrun
      n = 0; while (o_state != 2'd0 && n < 20) begin @(negedge clk); n++; end
      bound("t5_idle", n, 20);
      n = 0; while (!o_start && n < 50) begin @(negedge clk); n++; end
      bound("t5_start", n, 50);
      hold = 1'b1;
      repeat (15) @(negedge clk);
      hold = 1'b0;
      chk("t5_overrun", 64'(o_overrun), 64'd1);
      n = 0; while (o_state != 2'd2 && n < 50) begin @(negedge clk); n++; end
      bound("t5_done", n, 50);
      @(negedge clk);
      chk("t5_ptr", 64'(o_wr_ptr), 64'd7);
      n = 0; while (!o_start && n < 50) begin @(negedge clk); n++; end
      bound("t5_next", n, 50);
      chk("t5_next_addr", 64'(o_ddr_addr), 64'h1038);
      flag = 1'b1;
      repeat (3) @(negedge clk);
      rearm = 1'b1; @(negedge clk); rearm = 1'b0;
      chk("t5_rearm_ignored", 64'(o_overrun), 64'd1);
      flag = 1'b0; @(negedge clk);
      rearm = 1'b1; @(negedge clk); rearm = 1'b0;
      chk("t5_rearm_ovr", 64'(o_overrun), 64'd0);
      chk("t5_rearm_trig", 64'(o_triggered), 64'd0);
      n = 0; while (!o_start && n < 50) begin @(negedge clk); n++; end
      bound("t5_resume", n, 50);

      // reset in the middle of a write burst
      n = 0; while (!o_start && n < 50) begin @(negedge clk); n++; end
      bound("t6_start", n, 50);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_start_drop", 64'(o_start), 64'd0);
      chk("t6_wr_ptr", 64'(o_wr_ptr), 64'd0);
      chk("t6_state", 64'(o_state), 64'd0);
      chk("t6_addr", 64'(o_ddr_addr), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0; while (!o_start && n < 50) begin @(negedge clk); n++; end
      bound("t6_resume", n, 50);
      chk("t6_resume_addr", 64'(o_ddr_addr), 64'h1000);
      repeat (30) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
